// File: rtl/queue_pkg.sv
// ============================================================================
// Module   : queue_pkg
// Brief    : Shared types and geometry for the queue drain serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package queue_pkg;

    localparam int c_ENTRY_W         = 96;
    localparam int c_WORD_W          = 32;
    localparam int c_WORDS_PER_ENTRY = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_t;

endpackage : queue_pkg

`default_nettype wire

// File: rtl/queue_drain_serializer.sv
// ============================================================================
// Module   : queue_drain_serializer
// Brief    : Pops 96-bit queue entries and emits them as three 32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_drain_serializer
    import queue_pkg::*;
#(
    parameter int WORD_ORDER = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    output logic                   TIE_INQ1_PopReq,
    input  logic [c_ENTRY_W-1:0]   TIE_INQ1,
    input  logic                   TIE_INQ1_Empty,
    input  logic                   FLUSH,
    output logic                   OUT_Valid,
    output logic [c_WORD_W-1:0]    OUT_Data,
    output logic                   OUT_Last,
    input  logic                   OUT_Ready,
    output logic [CNT_W-1:0]       ENTRY_CNT
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_ENTRY_W-1:0]   r_hold;
    logic [CNT_W-1:0]       r_entry_cnt;
    logic                   w_accept;
    logic                   w_pop;
    logic [1:0]             w_slot;
    logic [1:0]             w_word_idx;

    // Reset gates the pop so an in-reset queue is never drained.
    assign w_pop = RST_N & ~TIE_INQ1_Empty & ~FLUSH &
                   ((r_state == ST_IDLE) | ((r_state == ST_W2) & OUT_Ready));

    assign TIE_INQ1_PopReq = w_pop;
    assign OUT_Valid       = (r_state != ST_IDLE);
    assign OUT_Last        = (r_state == ST_W2);
    assign w_accept        = OUT_Valid & OUT_Ready;
    assign ENTRY_CNT       = r_entry_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_slot      = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) w_state_nxt = ST_W0;
            end
            ST_W0: begin
                w_slot = 2'd0;
                if (w_accept) w_state_nxt = ST_W1;
            end
            ST_W1: begin
                w_slot = 2'd1;
                if (w_accept) w_state_nxt = ST_W2;
            end
            ST_W2: begin
                w_slot = 2'd2;
                if (w_accept) w_state_nxt = w_pop ? ST_W0 : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (FLUSH) w_state_nxt = ST_IDLE;
    end

    assign w_word_idx = (WORD_ORDER != 0) ? (2'd2 - w_slot) : w_slot;

    always_comb begin
        OUT_Data = '0;
        if (r_state != ST_IDLE) begin
            case (w_word_idx)
                2'd0:    OUT_Data = r_hold[0*c_WORD_W +: c_WORD_W];
                2'd1:    OUT_Data = r_hold[1*c_WORD_W +: c_WORD_W];
                2'd2:    OUT_Data = r_hold[2*c_WORD_W +: c_WORD_W];
                default: OUT_Data = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_entry_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (FLUSH) begin
                r_hold <= '0;
            end else if (w_pop) begin
                r_hold <= TIE_INQ1;
            end
            // A flush voids the entry, so a coinciding last-word accept is not counted.
            if (!FLUSH && w_accept && (r_state == ST_W2)) begin
                r_entry_cnt <= r_entry_cnt + CNT_W'(1);
            end
        end
    end

endmodule : queue_drain_serializer

`default_nettype wire

// File: tb/tb_queue_drain_serializer.sv
// ============================================================================
// Module   : tb_queue_drain_serializer
// Brief    : Directed table plus randomized model check of the serializer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_queue_drain_serializer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [95:0] TIE_INQ1;
    logic        TIE_INQ1_Empty;
    logic        FLUSH;
    logic        OUT_Ready;

    logic        a_pop, a_valid, a_last;
    logic [31:0] a_data;
    logic [15:0] a_cnt;
    logic        b_pop, b_valid, b_last;
    logic [31:0] b_data;
    logic [3:0]  b_cnt;

    always #5 CLK = ~CLK;

    queue_drain_serializer #(.WORD_ORDER(0), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .TIE_INQ1_PopReq(a_pop), .TIE_INQ1(TIE_INQ1),
        .TIE_INQ1_Empty(TIE_INQ1_Empty), .FLUSH(FLUSH), .OUT_Valid(a_valid),
        .OUT_Data(a_data), .OUT_Last(a_last), .OUT_Ready(OUT_Ready), .ENTRY_CNT(a_cnt)
    );

    queue_drain_serializer #(.WORD_ORDER(1), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .TIE_INQ1_PopReq(b_pop), .TIE_INQ1(TIE_INQ1),
        .TIE_INQ1_Empty(TIE_INQ1_Empty), .FLUSH(FLUSH), .OUT_Valid(b_valid),
        .OUT_Data(b_data), .OUT_Last(b_last), .OUT_Ready(OUT_Ready), .ENTRY_CNT(b_cnt)
    );

    typedef struct packed {
        logic        ready;
        logic        flush;
        logic        pre;
        logic [95:0] pre_data;
        logic        e_pop;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_datb;
        logic        e_last;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        vt [26];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [95:0] q [$];
    logic [31:0] rem_a [$];
    logic [31:0] rem_b [$];
    int unsigned cnt_m;
    bit          model_on;
    int          valid_seen;
    int          pops_seen;

    task automatic drive_q();
        TIE_INQ1_Empty = (q.size() == 0);
        TIE_INQ1       = (q.size() > 0) ? q[0] : 96'h0;
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: outstanding words of the current entry, in emission order.
    task automatic model_check(input bit exp_pop);
        bit busy;
        busy = (rem_a.size() > 0);
        chk("a_pop",   a_pop,   exp_pop);
        chk("b_pop",   b_pop,   exp_pop);
        chk("a_valid", a_valid, busy);
        chk("b_valid", b_valid, busy);
        chk("a_data",  a_data,  busy ? rem_a[0] : 32'h0);
        chk("b_data",  b_data,  busy ? rem_b[0] : 32'h0);
        chk("a_last",  a_last,  rem_a.size() == 1);
        chk("b_last",  b_last,  rem_b.size() == 1);
        chk("a_cnt",   a_cnt,   cnt_m % 65536);
        chk("b_cnt",   b_cnt,   cnt_m % 16);
    endtask

    task automatic model_edge(input bit ready, input bit flush, input bit popped,
                              input logic [95:0] head);
        if (flush) begin
            rem_a.delete();
            rem_b.delete();
        end else begin
            if (rem_a.size() > 0 && ready) begin
                if (rem_a.size() == 1) cnt_m++;
                void'(rem_a.pop_front());
                void'(rem_b.pop_front());
            end
            if (popped) begin
                rem_a.push_back(head[31:0]);
                rem_a.push_back(head[63:32]);
                rem_a.push_back(head[95:64]);
                rem_b.push_back(head[95:64]);
                rem_b.push_back(head[63:32]);
                rem_b.push_back(head[31:0]);
            end
        end
    endtask

    task automatic q_edge(input bit dut_pop, input bit do_push, input logic [95:0] pdata);
        if (dut_pop && q.size() > 0) void'(q.pop_front());
        if (do_push && q.size() < 4) q.push_back(pdata);
        drive_q();
    endtask

    task automatic step(input bit ready, input bit flush, input bit do_push,
                        input logic [95:0] pdata);
        bit          exp_pop;
        bit          dut_pop;
        logic [95:0] head;
        OUT_Ready = ready;
        FLUSH     = flush;
        @(negedge CLK);
        exp_pop = (q.size() != 0) && !flush &&
                  (rem_a.size() == 0 || (rem_a.size() == 1 && ready));
        if (model_on) model_check(exp_pop);
        dut_pop = a_pop;
        head    = TIE_INQ1;
        if (a_valid) valid_seen++;
        if (a_pop) pops_seen++;
        @(posedge CLK);
        #1;
        if (model_on) model_edge(ready, flush, exp_pop, head);
        q_edge(dut_pop, do_push, pdata);
    endtask

    // Called just after a rising edge; the pulse lies wholly between edges.
    task automatic pulse_reset();
        #1 RST_N = 1'b0;
        #1;
        chk("rst_pop",   {a_pop, b_pop},     2'b00);
        chk("rst_valid", {a_valid, b_valid}, 2'b00);
        chk("rst_last",  {a_last, b_last},   2'b00);
        chk("rst_data",  {a_data, b_data},   64'h0);
        chk("rst_cnt",   {a_cnt, b_cnt},     20'h0);
        #1 RST_N = 1'b1;
        rem_a.delete();
        rem_b.delete();
        cnt_m = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q.size() > 0 || rem_a.size() > 0); k++)
            step(1'b1, 1'b0, 1'b0, 96'h0);
        chk("drain_left", q.size() + rem_a.size(), 0);
    endtask

    initial begin
        vt[0]  = '{1,0,0,96'h0,1,0,32'h0, 32'h0, 0,16'd0};
        vt[1]  = '{1,0,0,96'h0,0,1,32'h1, 32'h3, 0,16'd0};
        vt[2]  = '{0,0,0,96'h0,0,1,32'h2, 32'h2, 0,16'd0};
        vt[3]  = '{0,0,0,96'h0,0,1,32'h2, 32'h2, 0,16'd0};
        vt[4]  = '{1,0,0,96'h0,0,1,32'h2, 32'h2, 0,16'd0};
        vt[5]  = '{1,0,0,96'h0,0,1,32'h3, 32'h1, 1,16'd0};
        vt[6]  = '{1,0,0,96'h0,0,0,32'h0, 32'h0, 0,16'd1};
        vt[7]  = '{1,0,1,96'h0000000c_0000000b_0000000a,1,0,32'h0,32'h0,0,16'd1};
        vt[8]  = '{1,0,1,96'h0000000f_0000000e_0000000d,0,1,32'ha,32'hc,0,16'd1};
        vt[9]  = '{1,1,0,96'h0,0,1,32'hb, 32'hb, 0,16'd1};
        vt[10] = '{1,0,0,96'h0,1,0,32'h0, 32'h0, 0,16'd1};
        vt[11] = '{1,0,0,96'h0,0,1,32'hd, 32'hf, 0,16'd1};
        vt[12] = '{1,0,0,96'h0,0,1,32'he, 32'he, 0,16'd1};
        vt[13] = '{1,0,0,96'h0,0,1,32'hf, 32'hd, 1,16'd1};
        vt[14] = '{1,0,0,96'h0,0,0,32'h0, 32'h0, 0,16'd2};
        vt[15] = '{1,0,1,96'h00000012_00000011_00000010,1,0,32'h0,32'h0,0,16'd2};
        vt[16] = '{1,0,0,96'h0,0,1,32'h10,32'h12,0,16'd2};
        vt[17] = '{1,0,0,96'h0,0,1,32'h11,32'h11,0,16'd2};
        vt[18] = '{1,1,0,96'h0,0,1,32'h12,32'h10,1,16'd2};
        vt[19] = '{1,0,0,96'h0,0,0,32'h0, 32'h0, 0,16'd2};
        vt[20] = '{1,1,1,96'h00000015_00000014_00000013,0,0,32'h0,32'h0,0,16'd2};
        vt[21] = '{1,0,0,96'h0,1,0,32'h0, 32'h0, 0,16'd2};
        vt[22] = '{1,0,0,96'h0,0,1,32'h13,32'h15,0,16'd2};
        vt[23] = '{1,0,0,96'h0,0,1,32'h14,32'h14,0,16'd2};
        vt[24] = '{1,0,0,96'h0,0,1,32'h15,32'h13,1,16'd2};
        vt[25] = '{1,0,0,96'h0,0,0,32'h0, 32'h0, 0,16'd3};

        RST_N     = 1'b0;
        FLUSH     = 1'b0;
        OUT_Ready = 1'b0;
        model_on  = 1'b0;
        drive_q();
        repeat (2) @(posedge CLK);
        #1;
        q.push_back(96'h00000003_00000002_00000001);
        drive_q();
        #1;
        chk("init_pop",   {a_pop, b_pop},     2'b00);
        chk("init_valid", {a_valid, b_valid}, 2'b00);
        chk("init_data",  {a_data, b_data},   64'h0);
        chk("init_cnt",   {a_cnt, b_cnt},     20'h0);
        #1 RST_N = 1'b1;

        for (int i = 0; i < 26; i++) begin
            bit dp;
            if (vt[i].pre) begin
                q.push_back(vt[i].pre_data);
                drive_q();
            end
            OUT_Ready = vt[i].ready;
            FLUSH     = vt[i].flush;
            @(negedge CLK);
            chk($sformatf("v%0d_pop", i),   a_pop,   vt[i].e_pop);
            chk($sformatf("v%0d_valid", i), a_valid, vt[i].e_valid);
            chk($sformatf("v%0d_data", i),  a_data,  vt[i].e_data);
            chk($sformatf("v%0d_datb", i),  b_data,  vt[i].e_datb);
            chk($sformatf("v%0d_last", i),  a_last,  vt[i].e_last);
            chk($sformatf("v%0d_cnt", i),   a_cnt,   vt[i].e_cnt);
            dp = a_pop;
            @(posedge CLK);
            #1;
            q_edge(dp, 1'b0, 96'h0);
        end

        cnt_m    = 3;
        model_on = 1'b1;
        drain();

        // Back-to-back: a full queue streams 12 words with no bubble.
        for (int k = 0; k < 4; k++) q.push_back({$urandom(), $urandom(), $urandom()});
        drive_q();
        valid_seen = 0;
        pops_seen  = 0;
        for (int k = 0; k < 13; k++) step(1'b1, 1'b0, 1'b0, 96'h0);
        chk("b2b_valid_cycles", valid_seen, 12);
        chk("b2b_pops", pops_seen, 4);
        drain();

        // Five cycles of backpressure while the middle word is presented.
        q.push_back({$urandom(), $urandom(), $urandom()});
        drive_q();
        step(1'b1, 1'b0, 1'b0, 96'h0);
        step(1'b1, 1'b0, 1'b0, 96'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 96'h0);
        drain();

        // Reset while the third word of the first of three entries is shown.
        for (int k = 0; k < 3; k++) q.push_back({$urandom(), $urandom(), $urandom()});
        drive_q();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 96'h0);
        chk("w2_before_rst", a_last, 1'b1);
        pulse_reset();
        drain();
        chk("cnt_after_rst_drain", a_cnt, 16'd2);

        // Seventeen entries wrap the 4-bit counter to 1.
        @(posedge CLK);
        #1;
        pulse_reset();
        begin
            int pushed;
            pushed = 0;
            for (int k = 0; k < 200 && (pushed < 17 || q.size() > 0 || rem_a.size() > 0); k++) begin
                bit p;
                p = (pushed < 17) && (q.size() < 4);
                step(1'b1, 1'b0, p, {$urandom(), $urandom(), $urandom()});
                if (p) pushed++;
            end
        end
        chk("wrap_b_cnt", b_cnt, 4'd1);
        chk("wrap_a_cnt", a_cnt, 16'd17);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, {$urandom(), $urandom(), $urandom()});
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_queue_drain_serializer

`default_nettype wire

// File: doc/queue_drain_serializer.md
QUEUE_DRAIN_SERIALIZER -- requirements
Module: queue_drain_serializer

Interface
REQ-001 SHALL have parameter WORD_ORDER, default 0, meaning 0 = emit bits [31:0] first and 1 = emit bits [95:64] first.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the drained-entry counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 TIE_INQ1_PopReq  output  1  pop request to the upstream 4-entry queue.
REQ-007 TIE_INQ1  input  96  queue head entry; valid whenever TIE_INQ1_Empty=0.
REQ-008 TIE_INQ1_Empty  input  1  queue empty flag.
REQ-009 FLUSH  input  1  synchronous abort of the entry in flight.
REQ-010 OUT_Valid  output  1  OUT_Data holds a word.
REQ-011 OUT_Data  output  32  current word.
REQ-012 OUT_Last  output  1  current word is the third word of its entry.
REQ-013 OUT_Ready  input  1  sink accepts the word when OUT_Valid=1 and OUT_Ready=1 at a rising edge.
REQ-014 ENTRY_CNT  output  CNT_W  count of entries fully emitted, wrapping modulo 2^CNT_W.

Function
REQ-015 SHALL implement FSM states IDLE, W0, W1, W2, with the state encoding held in a register.
REQ-016 SHALL drive TIE_INQ1_PopReq combinationally as: (TIE_INQ1_Empty=0) AND (FLUSH=0) AND ((state=IDLE) OR (state=W2 AND OUT_Ready=1)).
REQ-017 SHALL capture TIE_INQ1 into a 96-bit hold register on the same rising edge at which TIE_INQ1_PopReq=1, and SHALL move to W0 on that edge.
REQ-018 SHALL perform the transitions W0->W1 and W1->W2 on acceptance (OUT_Valid AND OUT_Ready); otherwise the FSM holds state.
REQ-019 On acceptance in W2, SHALL move to W0 if a pop occurs in that cycle, else to IDLE, so back-to-back entries stream at 1 word per cycle with no bubble.
REQ-020 SHALL set OUT_Valid=1 exactly in W0, W1 and W2.
REQ-021 SHALL set OUT_Last=1 only in W2.
REQ-022 With WORD_ORDER=0, OUT_Data SHALL be hold[31:0] in W0, hold[63:32] in W1 and hold[95:64] in W2; WORD_ORDER=1 reverses this order.
REQ-023 SHALL keep OUT_Data and OUT_Valid stable while OUT_Valid=1 and OUT_Ready=0.
REQ-024 SHALL output OUT_Data=0 in IDLE.
REQ-025 SHALL increment ENTRY_CNT by 1 on each W2 acceptance, with no saturation, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 FLUSH=1 SHALL force the next state to IDLE from any state, discard the held entry, suppress the pop in that cycle, and leave ENTRY_CNT unchanged even if a W2 acceptance coincides.
REQ-027 SHALL let an empty queue in IDLE hold IDLE with TIE_INQ1_PopReq=0; when Empty rises during W0-W2, the current entry still completes.
REQ-028 Minimum latency SHALL be 1 cycle: an entry visible in IDLE gives OUT_Valid=1 in the cycle after the pop edge.

Reset
REQ-029 RST_N low SHALL immediately set state=IDLE, hold register=0 and ENTRY_CNT=0, and SHALL force OUT_Valid=0, OUT_Last=0, OUT_Data=0 and TIE_INQ1_PopReq=0 regardless of TIE_INQ1_Empty.
REQ-030 Reset asserted mid-entry SHALL discard that entry without popping further; after RST_N rises, operation SHALL resume at the first rising edge.

Structure
REQ-031 The state encoding, the entry width (96), word width (32) and words-per-entry (3) SHALL be defined in the shared package queue_pkg.
REQ-032 SHALL be a single module with no sub-modules; the word select is an inline mux.

Verification
REQ-033 Single entry: push 0x000000030000000200000001 into the queue with OUT_Ready=1 -> OUT_Data sequence 0x1, 0x2, 0x3 on 3 consecutive cycles, OUT_Last on 0x3, ENTRY_CNT=1, exactly one pop.
REQ-034 Back-to-back: 4 entries queued (queue full), OUT_Ready=1 -> 12 words on 12 consecutive cycles with no bubble, and the queue's Full flag drops after the first pop.
REQ-035 Backpressure: OUT_Ready=0 for 5 cycles while in W1 -> OUT_Data holds hold[63:32], no state change, no pop; resumes when OUT_Ready=1.
REQ-036 FLUSH asserted in W1 with 2 entries queued -> IDLE next cycle, ENTRY_CNT unchanged, next entry popped the following cycle and emitted from W0.
REQ-037 RST_N pulsed low asynchronously mid-W2 -> all outputs 0 within the pulse, ENTRY_CNT=0, and the remaining queue entries drain normally after release.
REQ-038 Wrap: with CNT_W=4, drain 17 entries -> ENTRY_CNT=1; with WORD_ORDER=1, the first word is hold[95:64].
